// File: rtl/video_host_regs_if.sv
// Cart-bus handshake between the host register file (master) and the cartridge/VRAM side (slave).
interface video_host_regs_if;
  logic        req;
  logic        ack;
  logic [13:0] addr;
  logic        wren;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (
    output req,
    output addr,
    output wren,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    input  wren,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/video_host_regs.sv
// Host-facing register file of the picture unit: register decode, scroll/address latches, status/NMI, cart VRAM FSM.
// Optional open-bus decay is enabled by defining VIDEO_HOST_REGS_DECAY_EN.
module video_host_regs #(
  parameter logic [15:0] DECAY_TICKS = 16'd50000
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_host_strobe,
  input  logic [2:0]  I_host_addr,
  input  logic        I_host_wren,
  input  logic [7:0]  I_host_data,
  output logic [7:0]  O_host_data,
  output logic        O_host_nmi,
  input  logic        I_vblank_set,
  input  logic        I_vblank_clear,
  input  logic        I_spr0_hit,
  input  logic        I_spr_ovf,
  output logic [7:0]  O_ctrl,
  output logic [7:0]  O_mask,
  output logic [14:0] O_vram_v,
  output logic [14:0] O_vram_t,
  output logic [2:0]  O_fine_x,
  output logic [7:0]  O_oam_addr,
  output logic        O_oam_wren,
  output logic [7:0]  O_oam_data,
  input  logic [7:0]  I_oam_data,
  output logic [4:0]  O_pal_addr,
  output logic        O_pal_wren,
  output logic [5:0]  O_pal_data,
  input  logic [5:0]  I_pal_data,
  video_host_regs_if.master cart
);

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_ctrl;
  logic [7:0]  r_mask;
  logic [14:0] r_v;
  logic [14:0] r_t;
  logic [2:0]  r_fine_x;
  logic        r_w;
  logic [7:0]  r_oam_addr;
  logic        r_oam_wren;
  logic [7:0]  r_oam_data;
  logic        r_oam_inc;
  logic        r_pal_wren;
  logic [4:0]  r_pal_waddr;
  logic [5:0]  r_pal_data;
  logic [7:0]  r_host_data;
  logic        r_nmi;
  logic        r_vblank;
  logic        r_spr0;
  logic        r_ovf;
  logic [7:0]  r_buffer;
  logic [7:0]  r_openbus;
  logic [13:0] r_cart_addr;
  logic [7:0]  r_cart_data;

  logic        w_wr;
  logic        w_rd;
  logic        w_idle;
  logic        w_pal_hit;
  logic        w_acc7;
  logic        w_pal_wr;
  logic        w_cart_start;
  logic        w_status_rd;
  logic        w_cart_req;
  logic        w_cart_wren;
  logic [14:0] w_v_inc;
  logic [7:0]  w_rd_data;

  // Host strobe decode; DATA accesses are only accepted while the cart FSM is idle.
  assign w_wr         = I_host_strobe & I_host_wren;
  assign w_rd         = I_host_strobe & ~I_host_wren;
  assign w_idle       = (r_state == ST_IDLE);
  assign w_pal_hit    = (r_v[13:8] == 6'h3F);
  assign w_acc7       = I_host_strobe & (I_host_addr == REG_DATA) & w_idle;
  assign w_pal_wr     = w_acc7 & I_host_wren & w_pal_hit;
  assign w_cart_start = w_acc7 & ~(I_host_wren & w_pal_hit);
  assign w_status_rd  = w_rd & (I_host_addr == REG_STATUS);
  assign w_v_inc      = r_ctrl[2] ? 15'd32 : 15'd1;

  always_comb begin
    w_rd_data = r_openbus;
    case (I_host_addr)
      REG_STATUS:  w_rd_data = {r_vblank, r_spr0, r_ovf, r_openbus[4:0]};
      REG_OAMDATA: w_rd_data = I_oam_data;
      REG_DATA:    w_rd_data = (w_idle && w_pal_hit) ? {r_openbus[7:6], I_pal_data} : r_buffer;
      default:     w_rd_data = r_openbus;
    endcase
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cart_req   = 1'b0;
    w_cart_wren  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cart_start) begin
          w_state_next = I_host_wren ? ST_WR_WAIT : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        w_cart_req = 1'b1;
        if (cart.ack) w_state_next = ST_IDLE;
      end
      ST_WR_WAIT: begin
        w_cart_req  = 1'b1;
        w_cart_wren = 1'b1;
        if (cart.ack) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Cart address/data are captured at the start of an access and stay frozen until ack.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_cart_addr <= 14'd0;
      r_cart_data <= 8'd0;
      r_buffer    <= 8'd0;
    end else begin
      if (w_cart_start) begin
        r_cart_addr <= (!I_host_wren && w_pal_hit) ? (r_v[13:0] & 14'h2FFF) : r_v[13:0];
        r_cart_data <= I_host_data;
      end
      if (r_state == ST_RD_WAIT && cart.ack) begin
        r_buffer <= cart.rdata;
      end
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_ctrl      <= 8'd0;
      r_mask      <= 8'd0;
      r_v         <= 15'd0;
      r_t         <= 15'd0;
      r_fine_x    <= 3'd0;
      r_w         <= 1'b0;
      r_oam_addr  <= 8'd0;
      r_oam_wren  <= 1'b0;
      r_oam_data  <= 8'd0;
      r_oam_inc   <= 1'b0;
      r_pal_wren  <= 1'b0;
      r_pal_waddr <= 5'd0;
      r_pal_data  <= 6'd0;
      r_host_data <= 8'd0;
    end else begin
      r_oam_wren <= 1'b0;
      r_pal_wren <= 1'b0;
      r_oam_inc  <= 1'b0;
      // OAM address advances the cycle after the write pulse so the pulse sees the old address.
      if (r_oam_inc) r_oam_addr <= r_oam_addr + 8'd1;

      if (w_rd) r_host_data <= w_rd_data;

      if (w_wr) begin
        case (I_host_addr)
          REG_CTRL: begin
            r_ctrl       <= I_host_data;
            r_t[11:10]   <= I_host_data[1:0];
          end
          REG_MASK:    r_mask <= I_host_data;
          REG_OAMADDR: r_oam_addr <= I_host_data;
          REG_OAMDATA: begin
            r_oam_wren <= 1'b1;
            r_oam_data <= I_host_data;
            r_oam_inc  <= 1'b1;
          end
          REG_SCROLL: begin
            if (!r_w) begin
              r_fine_x <= I_host_data[2:0];
              r_t[4:0] <= I_host_data[7:3];
            end else begin
              r_t[14:12] <= I_host_data[2:0];
              r_t[9:5]   <= I_host_data[7:3];
            end
          end
          REG_ADDR: begin
            if (!r_w) begin
              r_t[13:8] <= I_host_data[5:0];
              r_t[14]   <= 1'b0;
            end else begin
              r_t[7:0] <= I_host_data;
              r_v      <= {r_t[14:8], I_host_data};
            end
          end
          default: ;
        endcase
      end

      if (w_wr && (I_host_addr == REG_SCROLL || I_host_addr == REG_ADDR)) begin
        r_w <= ~r_w;
      end else if (w_status_rd) begin
        r_w <= 1'b0;
      end

      if (w_acc7) r_v <= r_v + w_v_inc;

      if (w_pal_wr) begin
        r_pal_wren  <= 1'b1;
        r_pal_waddr <= r_v[4:0];
        r_pal_data  <= I_host_data[5:0];
      end
    end
  end

  // A status read wins over a simultaneous vblank_set, which suppresses that frame's flag.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_vblank <= 1'b0;
      r_spr0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_nmi    <= 1'b0;
    end else begin
      if (w_status_rd || I_vblank_clear) r_vblank <= 1'b0;
      else if (I_vblank_set)             r_vblank <= 1'b1;

      if (I_vblank_clear)  r_spr0 <= 1'b0;
      else if (I_spr0_hit) r_spr0 <= 1'b1;

      if (I_vblank_clear) r_ovf <= 1'b0;
      else if (I_spr_ovf) r_ovf <= 1'b1;

      r_nmi <= r_vblank & r_ctrl[7];
    end
  end

`ifdef VIDEO_HOST_REGS_DECAY_EN
  logic [15:0] r_decay_cnt;
  logic        w_rd_full8;

  assign w_rd_full8 = (I_host_addr == REG_OAMDATA) ||
                      ((I_host_addr == REG_DATA) && !(w_idle && w_pal_hit));

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_openbus   <= 8'd0;
      r_decay_cnt <= 16'd0;
    end else if (w_wr) begin
      r_openbus   <= I_host_data;
      r_decay_cnt <= DECAY_TICKS;
    end else if (w_rd && w_rd_full8) begin
      r_decay_cnt <= DECAY_TICKS;
    end else if (r_decay_cnt != 16'd0) begin
      r_decay_cnt <= r_decay_cnt - 16'd1;
      if (r_decay_cnt == 16'd1) r_openbus <= 8'd0;
    end
  end
`else
  logic w_unused_decay;

  assign w_unused_decay = ^DECAY_TICKS;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_openbus <= 8'd0;
    end else if (w_wr) begin
      r_openbus <= I_host_data;
    end
  end
`endif

  // During the write pulse the palette port shows the captured address; otherwise it tracks v.
  assign O_pal_addr  = r_pal_wren ? r_pal_waddr : r_v[4:0];
  assign O_pal_wren  = r_pal_wren;
  assign O_pal_data  = r_pal_data;

  assign O_host_data = r_host_data;
  assign O_host_nmi  = r_nmi;
  assign O_ctrl      = r_ctrl;
  assign O_mask      = r_mask;
  assign O_vram_v    = r_v;
  assign O_vram_t    = r_t;
  assign O_fine_x    = r_fine_x;
  assign O_oam_addr  = r_oam_addr;
  assign O_oam_wren  = r_oam_wren;
  assign O_oam_data  = r_oam_data;

  assign cart.req    = w_cart_req;
  assign cart.wren   = w_cart_wren;
  assign cart.addr   = r_cart_addr;
  assign cart.wdata  = r_cart_data;

endmodule

// File: tb/tb_video_host_regs.sv
// Scoreboard bench for video_host_regs: directed scenarios plus randomized host traffic against a register-level model.
module tb_video_host_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic [2:0]  haddr = 3'd0;
  logic        hwren = 1'b0;
  logic [7:0]  hdata = 8'd0;
  logic [7:0]  host_rdata;
  logic        nmi;
  logic        vb_set = 1'b0, vb_clr = 1'b0, s0_hit = 1'b0, ovf_in = 1'b0;
  logic [7:0]  ctrl, mask, oam_addr, oam_wdata, oam_rdata;
  logic [14:0] vram_v, vram_t;
  logic [2:0]  fine_x;
  logic        oam_wren, pal_wren;
  logic [4:0]  pal_addr;
  logic [5:0]  pal_wdata, pal_rdata;
  logic [5:0]  pal_mem [32];

  video_host_regs_if cart_if();

  always #5 clk = ~clk;

  video_host_regs dut (
    .I_clock(clk), .I_reset(rst_n),
    .I_host_strobe(strobe), .I_host_addr(haddr), .I_host_wren(hwren), .I_host_data(hdata),
    .O_host_data(host_rdata), .O_host_nmi(nmi),
    .I_vblank_set(vb_set), .I_vblank_clear(vb_clr), .I_spr0_hit(s0_hit), .I_spr_ovf(ovf_in),
    .O_ctrl(ctrl), .O_mask(mask), .O_vram_v(vram_v), .O_vram_t(vram_t), .O_fine_x(fine_x),
    .O_oam_addr(oam_addr), .O_oam_wren(oam_wren), .O_oam_data(oam_wdata), .I_oam_data(oam_rdata),
    .O_pal_addr(pal_addr), .O_pal_wren(pal_wren), .O_pal_data(pal_wdata), .I_pal_data(pal_rdata),
    .cart(cart_if.master)
  );

  // External memories seen by the DUT
  assign oam_rdata = oam_addr ^ 8'h5A;
  assign pal_rdata = pal_mem[pal_addr];

  typedef struct packed {
    logic [13:0] addr;
    logic        wren;
    logic [7:0]  data;
  } cart_t;

  cart_t       cart_q[$];
  logic [7:0]  cart_rd_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] oam_q[$];
  logic [10:0] pal_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  logic rd_seen = 1'b0;

  // Reference model state
  logic [7:0]  m_ctrl, m_mask, m_oam, m_buf, m_ob;
  logic [14:0] m_v, m_t;
  logic [2:0]  m_fx;
  logic        m_w, m_vb, m_s0, m_ov, m_busy;
  logic [5:0]  m_pal [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected DUT activity, expected none", name);
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_oam = 0; m_buf = 0; m_ob = 0;
    m_v = 0; m_t = 0; m_fx = 0; m_w = 0; m_vb = 0; m_s0 = 0; m_ov = 0; m_busy = 0;
  endtask

  function automatic logic [14:0] v_step(input logic [14:0] v, input logic [7:0] c);
    return v + (c[2] ? 15'd32 : 15'd1);
  endfunction

  // Host read monitor, OAM/palette write monitor
  initial forever begin
    @(posedge clk);
    rd_seen = strobe && !hwren;
  end

  initial forever begin
    @(negedge clk);
    if (rd_seen) begin
      if (rd_q.size() == 0) fail_unexpected("host_read");
      else check("host_rdata", {24'd0, host_rdata}, {24'd0, rd_q.pop_front()});
    end
    if (oam_wren) begin
      if (oam_q.size() == 0) fail_unexpected("oam_write");
      else check("oam_write", {16'd0, oam_addr, oam_wdata}, {16'd0, oam_q.pop_front()});
    end
    if (pal_wren) begin
      pal_mem[pal_addr] = pal_wdata;
      if (pal_q.size() == 0) fail_unexpected("pal_write");
      else check("pal_write", {21'd0, pal_addr, pal_wdata}, {21'd0, pal_q.pop_front()});
    end
  end

  // Cart responder: checks request stability every cycle, acks after ack_delay cycles
  initial begin
    cart_if.ack = 1'b0;
    cart_if.rdata = 8'd0;
    forever begin
      @(negedge clk);
      if (cart_if.ack) begin
        cart_if.ack = 1'b0;
        ack_cnt = 0;
      end else if (cart_if.req) begin
        if (cart_q.size() == 0) begin
          if (ack_cnt == 0) fail_unexpected("cart_req");
        end else begin
          check("cart_addr", {18'd0, cart_if.addr}, {18'd0, cart_q[0].addr});
          check("cart_wren", {31'd0, cart_if.wren}, {31'd0, cart_q[0].wren});
          if (cart_q[0].wren) check("cart_wdata", {24'd0, cart_if.wdata}, {24'd0, cart_q[0].data});
        end
        if (ack_cnt >= ack_delay) begin
          cart_if.ack = 1'b1;
          if (!cart_if.wren) cart_if.rdata = (cart_rd_q.size() != 0) ? cart_rd_q.pop_front() : 8'hEE;
          if (cart_q.size() != 0) void'(cart_q.pop_front());
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  task automatic strobe_cycle(input logic [2:0] a, input logic wr, input logic [7:0] d);
    @(negedge clk);
    strobe = 1'b1; haddr = a; hwren = wr; hdata = d;
    @(negedge clk);
    strobe = 1'b0; hwren = 1'b0;
  endtask

  task automatic wait_cart_done();
    int n = 0;
    while (cart_if.req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cart_if.req) begin
      n_cmp++; n_bad++;
      $display("FAIL cart_timeout: got req still high after %0d cycles, expected completion", n);
    end
    m_busy = 1'b0;
  endtask

  task automatic check_regs();
    check("ctrl", {24'd0, ctrl}, {24'd0, m_ctrl});
    check("mask", {24'd0, mask}, {24'd0, m_mask});
    check("vram_v", {17'd0, vram_v}, {17'd0, m_v});
    check("vram_t", {17'd0, vram_t}, {17'd0, m_t});
    check("fine_x", {29'd0, fine_x}, {29'd0, m_fx});
    check("oam_addr", {24'd0, oam_addr}, {24'd0, m_oam});
    check("nmi", {31'd0, nmi}, {31'd0, (m_vb & m_ctrl[7])});
    if (!m_busy) check("cart_req_idle", {31'd0, cart_if.req}, 32'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    check_regs();
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d, input bit nowait = 1'b0);
    bit started = 1'b0;
    case (a)
      3'd0: begin m_ctrl = d; m_t[11:10] = d[1:0]; end
      3'd1: m_mask = d;
      3'd3: m_oam = d;
      3'd4: begin oam_q.push_back({m_oam, d}); m_oam = m_oam + 8'd1; end
      3'd5: begin
        if (!m_w) begin m_fx = d[2:0]; m_t[4:0] = d[7:3]; end
        else begin m_t[14:12] = d[2:0]; m_t[9:5] = d[7:3]; end
        m_w = !m_w;
      end
      3'd6: begin
        if (!m_w) begin m_t[13:8] = d[5:0]; m_t[14] = 1'b0; end
        else begin m_t[7:0] = d; m_v = m_t; end
        m_w = !m_w;
      end
      3'd7: begin
        if (!m_busy) begin
          if (m_v[13:8] == 6'h3F) pal_q.push_back({m_v[4:0], d[5:0]});
          else begin
            cart_q.push_back('{addr: m_v[13:0], wren: 1'b1, data: d});
            m_busy = 1'b1;
            started = 1'b1;
          end
          m_v = v_step(m_v, m_ctrl);
        end
      end
      default: ;
    endcase
    m_ob = d;
    $display("[%0t] host write reg%0d <= %h", $time, a, d);
    strobe_cycle(a, 1'b1, d);
    if (!nowait) begin
      if (started) wait_cart_done();
      settle();
    end
  endtask

  task automatic host_rd(input logic [2:0] a, input bit nowait = 1'b0);
    logic [7:0] exp;
    logic [7:0] nd;
    bit started = 1'b0;
    exp = m_ob;
    case (a)
      3'd2: begin exp = {m_vb, m_s0, m_ov, m_ob[4:0]}; m_vb = 1'b0; m_w = 1'b0; end
      3'd4: exp = m_oam ^ 8'h5A;
      3'd7: begin
        if (m_busy) exp = m_buf;
        else begin
          nd = 8'($urandom_range(0, 255));
          if (m_v[13:8] == 6'h3F) begin
            exp = {m_ob[7:6], m_pal[m_v[4:0]]};
            cart_q.push_back('{addr: m_v[13:0] & 14'h2FFF, wren: 1'b0, data: 8'd0});
          end else begin
            exp = m_buf;
            cart_q.push_back('{addr: m_v[13:0], wren: 1'b0, data: 8'd0});
          end
          cart_rd_q.push_back(nd);
          m_buf = nd;
          m_busy = 1'b1;
          started = 1'b1;
          m_v = v_step(m_v, m_ctrl);
        end
      end
      default: ;
    endcase
    rd_q.push_back(exp);
    $display("[%0t] host read reg%0d expect %h", $time, a, exp);
    strobe_cycle(a, 1'b0, 8'd0);
    if (!nowait) begin
      if (started) wait_cart_done();
      settle();
    end
  endtask

  task automatic pulse_flags(input logic set, input logic clr, input logic hit, input logic ov);
    if (clr) begin m_vb = 0; m_s0 = 0; m_ov = 0; end
    else begin
      if (set) m_vb = 1'b1;
      if (hit) m_s0 = 1'b1;
      if (ov)  m_ov = 1'b1;
    end
    $display("[%0t] flags set=%0b clr=%0b spr0=%0b ovf=%0b", $time, set, clr, hit, ov);
    @(negedge clk);
    vb_set = set; vb_clr = clr; s0_hit = hit; ovf_in = ov;
    @(negedge clk);
    vb_set = 0; vb_clr = 0; s0_hit = 0; ovf_in = 0;
    settle();
  endtask

  task automatic drop_test();
    ack_delay = 4;
    host_wr(3'd7, 8'($urandom_range(0, 255)), 1'b1);
    host_rd(3'd7, 1'b1);
    wait_cart_done();
    settle();
  endtask

  initial begin
    logic [2:0] a;
    logic       wr;
    logic [7:0] d;
    int         r;

    for (int i = 0; i < 32; i++) begin pal_mem[i] = 6'd0; m_pal[i] = 6'd0; end
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, cart_if.req}, 32'd0);
    check("rst_nmi", {31'd0, nmi}, 32'd0);
    check("rst_hdata", {24'd0, host_rdata}, 32'd0);
    rst_n = 1'b1;
    settle();
    host_rd(3'd2);

    // Scroll writes and w toggle
    host_wr(3'd5, 8'h7D);
    host_wr(3'd5, 8'h5E);
    check("t_616F", {17'd0, vram_t}, 32'h616F);
    host_rd(3'd2);
    host_wr(3'd5, 8'h3A);

    // Address latch and cart write with a held request
    host_rd(3'd2);
    host_wr(3'd6, 8'h21);
    host_wr(3'd6, 8'h08);
    check("v_2108", {17'd0, vram_v}, 32'h2108);
    ack_delay = 2;
    host_wr(3'd7, 8'hAB);
    check("v_2109", {17'd0, vram_v}, 32'h2109);

    // Increment-by-32 wrap from 7FF0, buffered reads
    host_wr(3'd0, 8'h04);
    host_rd(3'd2);
    host_wr(3'd6, 8'h3F);
    host_wr(3'd5, 8'hFF);
    host_wr(3'd5, 8'h80);
    host_wr(3'd6, 8'hF0);
    check("v_7FF0", {17'd0, vram_v}, 32'h7FF0);
    ack_delay = 1;
    host_rd(3'd7);
    check("v_wrap", {17'd0, vram_v}, 32'h0010);
    host_rd(3'd7);

    // Palette write: no cart traffic
    host_wr(3'd0, 8'h00);
    host_rd(3'd2);
    host_wr(3'd6, 8'h3F);
    host_wr(3'd6, 8'h05);
    host_wr(3'd7, 8'hFF);
    m_pal[5] = 6'h3F;

    // OAM
    host_wr(3'd3, 8'hFE);
    host_wr(3'd4, 8'h11);
    host_wr(3'd4, 8'h22);
    host_rd(3'd4);

    // Vblank / NMI / suppression / clear priority
    host_wr(3'd0, 8'h80);
    pulse_flags(1'b1, 1'b0, 1'b1, 1'b1);
    host_rd(3'd2);
    rd_q.push_back({1'b0, m_s0, m_ov, m_ob[4:0]});
    m_w = 1'b0;
    $display("[%0t] host read reg2 with coincident vblank_set", $time);
    @(negedge clk);
    strobe = 1'b1; haddr = 3'd2; hwren = 1'b0; vb_set = 1'b1;
    @(negedge clk);
    strobe = 1'b0; vb_set = 1'b0;
    settle();
    settle();
    pulse_flags(1'b1, 1'b1, 1'b0, 1'b0);

    // Busy drop
    host_rd(3'd2);
    host_wr(3'd6, 8'h12);
    host_wr(3'd6, 8'h34);
    drop_test();

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      ack_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 8) begin
        pulse_flags(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 12) begin
        drop_test();
      end else begin
        a  = 3'($urandom_range(0, 7));
        wr = 1'($urandom_range(0, 1));
        d  = 8'($urandom_range(0, 255));
        if (a == 3'd6 && $urandom_range(0, 3) == 0) d = 8'h3F;
        if (!wr && a != 3'd2 && a != 3'd4 && a != 3'd7) wr = 1'b1;
        if (a == 3'd7 && wr && !m_busy && m_v[13:8] == 6'h3F) m_pal[m_v[4:0]] = d[5:0];
        if (wr) host_wr(a, d);
        else    host_rd(a);
      end
    end

    // Asynchronous reset during a cart access
    host_rd(3'd2);
    host_wr(3'd6, 8'h12);
    host_wr(3'd6, 8'h34);
    ack_delay = 20;
    host_wr(3'd7, 8'h5C, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_req", {31'd0, cart_if.req}, 32'd0);
    check("async_reset_v", {17'd0, vram_v}, 32'd0);
    cart_q.delete();
    cart_rd_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    host_rd(3'd2);
    settle();

    check("rd_q_drained", rd_q.size(), 32'd0);
    check("pal_q_drained", pal_q.size(), 32'd0);
    check("oam_q_drained", oam_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
